// File: rtl/chaos_pkg.sv
// Shared navigator state encoding and default constants for the viewport navigator.
package chaos_pkg;

  typedef enum logic [1:0] {
    NAV_WAIT_BLANK = 2'b00,
    NAV_APPLY      = 2'b01,
    NAV_DONE       = 2'b10
  } nav_state_e;

  localparam int unsigned DEF_COORD_W      = 10;
  localparam int unsigned DEF_X_INIT       = 300;
  localparam int unsigned DEF_Y_INIT       = 200;
  localparam int unsigned DEF_X_MAX        = 639;
  localparam int unsigned DEF_Y_MAX        = 479;
  localparam int unsigned DEF_STEP         = 2;
  localparam int unsigned DEF_ACCEL_FRAMES = 8;
  localparam int unsigned DEF_FAST_MUL     = 4;
  localparam bit          DEF_WRAP         = 1'b0;
  localparam int unsigned DEF_ZOOM_MAX     = 7;
  localparam int unsigned DEF_DISP_DELAY   = 6;
  localparam int unsigned DEF_CALC_DELAY   = 15;
  localparam int unsigned STARTUP_W        = 5;

endpackage

// File: rtl/viewport_nav_if.sv
// Key, blank, pixel and navigation-output bundle between the front panel/video side and viewport_nav.
interface viewport_nav_if import chaos_pkg::*; #(
  parameter int unsigned COORD_W = DEF_COORD_W
);
  logic               up, down, left, right;
  logic               zoom_in, zoom_out;
  logic               vnotactive;
  logic               pix_r, pix_g, pix_b;
  logic [COORD_W-1:0] origin_x, origin_y;
  logic [2:0]         zoom;
  logic               disp_enable, calc_enable;
  logic               red, green, blue;
  logic               frame_tick;

  modport master (
    output up, down, left, right, zoom_in, zoom_out, vnotactive, pix_r, pix_g, pix_b,
    input  origin_x, origin_y, zoom, disp_enable, calc_enable, red, green, blue, frame_tick
  );

  modport slave (
    input  up, down, left, right, zoom_in, zoom_out, vnotactive, pix_r, pix_g, pix_b,
    output origin_x, origin_y, zoom, disp_enable, calc_enable, red, green, blue, frame_tick
  );
endinterface

// File: rtl/viewport_nav_axis_step.sv
// One pan axis: applies a signed step to the origin with either clamping or modulo wrap.
module axis_step #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned LIMIT   = 639,
  parameter bit          WRAP    = 1'b0
) (
  input  logic [COORD_W-1:0] cur_i,
  input  logic               dec_i,
  input  logic               inc_i,
  input  logic [COORD_W:0]   step_i,
  output logic [COORD_W-1:0] nxt_o
);

  logic [COORD_W:0] ext;
  logic [COORD_W:0] sum;
  logic [COORD_W:0] diff;

  // One extra bit keeps the overshoot visible for the clamp compare.
  always_comb begin
    ext   = {1'b0, cur_i};
    sum   = ext + step_i;
    diff  = ext - step_i;
    nxt_o = cur_i;
    if (dec_i) begin
      if (WRAP)              nxt_o = COORD_W'(diff);
      else if (ext < step_i) nxt_o = '0;
      else                   nxt_o = COORD_W'(diff);
    end else if (inc_i) begin
      if (WRAP)                              nxt_o = COORD_W'(sum);
      else if (sum > (COORD_W + 1)'(LIMIT))  nxt_o = COORD_W'(LIMIT);
      else                                   nxt_o = COORD_W'(sum);
    end
  end

endmodule

// File: rtl/viewport_nav.sv
// Viewport navigator: once-per-blank pan/zoom with hold acceleration, startup enables, registered colour.
module viewport_nav import chaos_pkg::*; #(
  parameter int unsigned COORD_W      = DEF_COORD_W,
  parameter int unsigned X_INIT       = DEF_X_INIT,
  parameter int unsigned Y_INIT       = DEF_Y_INIT,
  parameter int unsigned X_MAX        = DEF_X_MAX,
  parameter int unsigned Y_MAX        = DEF_Y_MAX,
  parameter int unsigned STEP         = DEF_STEP,
  parameter int unsigned ACCEL_FRAMES = DEF_ACCEL_FRAMES,
  parameter int unsigned FAST_MUL     = DEF_FAST_MUL,
  parameter bit          WRAP         = DEF_WRAP,
  parameter int unsigned ZOOM_MAX     = DEF_ZOOM_MAX,
  parameter int unsigned DISP_DELAY   = DEF_DISP_DELAY,
  parameter int unsigned CALC_DELAY   = DEF_CALC_DELAY
) (
  input  logic          CLK,
  input  logic          RST,
  viewport_nav_if.slave nav
);

  localparam int unsigned HOLD_W = $clog2(ACCEL_FRAMES + 2);

  nav_state_e             state_q, state_d;
  logic                   vn_prev_q, tick_q, tick_d;
  logic [COORD_W-1:0]     ox_q, ox_d, oy_q, oy_d, x_nxt, y_nxt;
  logic [2:0]             zoom_q, zoom_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [STARTUP_W-1:0]   start_q, start_d;
  logic                   disp_q, disp_d, calc_q, calc_d;
  logic [2:0]             rgb_q, rgb_d;
  logic [COORD_W:0]       step;
  logic                   up_p, down_p, left_p, right_p, pan_any;

  always_comb begin
    up_p    = ~nav.up;
    down_p  = ~nav.down & nav.up;
    left_p  = ~nav.left;
    right_p = ~nav.right & nav.left;
    pan_any = ~(nav.up & nav.down & nav.left & nav.right);
    step    = (hold_q < HOLD_W'(ACCEL_FRAMES)) ? (COORD_W + 1)'(STEP)
                                               : (COORD_W + 1)'(STEP * FAST_MUL);
  end

  axis_step #(.COORD_W(COORD_W), .LIMIT(X_MAX), .WRAP(WRAP)) u_axis_x (
    .cur_i(ox_q), .dec_i(left_p), .inc_i(right_p), .step_i(step), .nxt_o(x_nxt)
  );

  axis_step #(.COORD_W(COORD_W), .LIMIT(Y_MAX), .WRAP(WRAP)) u_axis_y (
    .cur_i(oy_q), .dec_i(up_p), .inc_i(down_p), .step_i(step), .nxt_o(y_nxt)
  );

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    zoom_d  = zoom_q;
    hold_d  = hold_q;
    case (state_q)
      NAV_WAIT_BLANK: if (nav.vnotactive) state_d = NAV_APPLY;
      NAV_APPLY: begin
        state_d = NAV_DONE;
        ox_d    = x_nxt;
        oy_d    = y_nxt;
        if (!pan_any)                              hold_d = '0;
        else if (hold_q < HOLD_W'(ACCEL_FRAMES))   hold_d = hold_q + 1'b1;
        if (!nav.zoom_in) begin
          if (zoom_q < 3'(ZOOM_MAX)) zoom_d = zoom_q + 3'd1;
        end else if (!nav.zoom_out) begin
          if (zoom_q != 3'd0) zoom_d = zoom_q - 3'd1;
        end
      end
      NAV_DONE: if (!nav.vnotactive) state_d = NAV_WAIT_BLANK;
      default: state_d = NAV_WAIT_BLANK;
    endcase
  end

  // Enables compare against the post-increment count so they rise on the counting edge.
  always_comb begin
    tick_d  = nav.vnotactive & ~vn_prev_q;
    start_d = (tick_q && start_q != '1) ? start_q + 1'b1 : start_q;
    disp_d  = disp_q | (32'(start_d) >= DISP_DELAY);
    calc_d  = calc_q | (32'(start_d) >= CALC_DELAY);
    rgb_d   = disp_q ? {nav.pix_r, nav.pix_g, nav.pix_b} : rgb_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= NAV_WAIT_BLANK;
      vn_prev_q <= 1'b0;
      tick_q    <= 1'b0;
      ox_q      <= COORD_W'(X_INIT);
      oy_q      <= COORD_W'(Y_INIT);
      zoom_q    <= '0;
      hold_q    <= '0;
      start_q   <= '0;
      disp_q    <= 1'b0;
      calc_q    <= 1'b0;
      rgb_q     <= '1;
    end else begin
      state_q   <= state_d;
      vn_prev_q <= nav.vnotactive;
      tick_q    <= tick_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      zoom_q    <= zoom_d;
      hold_q    <= hold_d;
      start_q   <= start_d;
      disp_q    <= disp_d;
      calc_q    <= calc_d;
      rgb_q     <= rgb_d;
    end
  end

  assign nav.origin_x    = ox_q;
  assign nav.origin_y    = oy_q;
  assign nav.zoom        = zoom_q;
  assign nav.disp_enable = disp_q;
  assign nav.calc_enable = calc_q;
  assign nav.red         = rgb_q[2];
  assign nav.green       = rgb_q[1];
  assign nav.blue        = rgb_q[0];
  assign nav.frame_tick  = tick_q;

endmodule

// File: tb/tb_viewport_nav.sv
// Bench for viewport_nav: a clamping (default) and a wrapping instance against a per-blank reference model.
module tb_viewport_nav;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic up, down, left, right, zoom_in, zoom_out, vnotactive, pix_r, pix_g, pix_b;

  viewport_nav_if #(.COORD_W(10)) nav0 ();
  viewport_nav_if #(.COORD_W(10)) nav1 ();

  assign nav0.up = up;         assign nav1.up = up;
  assign nav0.down = down;     assign nav1.down = down;
  assign nav0.left = left;     assign nav1.left = left;
  assign nav0.right = right;   assign nav1.right = right;
  assign nav0.zoom_in = zoom_in;   assign nav1.zoom_in = zoom_in;
  assign nav0.zoom_out = zoom_out; assign nav1.zoom_out = zoom_out;
  assign nav0.vnotactive = vnotactive; assign nav1.vnotactive = vnotactive;
  assign nav0.pix_r = pix_r;   assign nav1.pix_r = pix_r;
  assign nav0.pix_g = pix_g;   assign nav1.pix_g = pix_g;
  assign nav0.pix_b = pix_b;   assign nav1.pix_b = pix_b;

  viewport_nav u_clamp (.CLK(clk), .RST(rst_n), .nav(nav0));
  viewport_nav #(.X_INIT(0), .Y_INIT(0), .WRAP(1'b1)) u_wrap (.CLK(clk), .RST(rst_n), .nav(nav1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = clamping instance, 1 = wrapping instance.
  int  m_x[2], m_y[2], m_z[2], m_h[2];
  int  m_ticks;
  int  m_rgb;
  int  x_init[2] = '{300, 0};
  int  y_init[2] = '{200, 0};
  bit  m_wrap[2] = '{1'b0, 1'b1};

  int tick_seen = 0;
  int tick_base = 0;
  always @(negedge clk) if (nav0.frame_tick === 1'b1) tick_seen <= tick_seen + 1;

  function automatic int move(input int cur, input int delta, input int lim, input bit wr);
    int v;
    v = cur + delta;
    if (wr) return ((v % 1024) + 1024) % 1024;
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = x_init[i];
      m_y[i] = y_init[i];
      m_z[i] = 0;
      m_h[i] = 0;
    end
    m_ticks = 0;
    m_rgb   = 7;
  endtask

  task automatic model_frame(input bit u, input bit d, input bit l, input bit r,
                             input bit zi, input bit zo);
    for (int i = 0; i < 2; i++) begin
      int st;
      st = (m_h[i] < 8) ? 2 : 8;
      if (u)      m_y[i] = move(m_y[i], -st, 479, m_wrap[i]);
      else if (d) m_y[i] = move(m_y[i],  st, 479, m_wrap[i]);
      if (l)      m_x[i] = move(m_x[i], -st, 639, m_wrap[i]);
      else if (r) m_x[i] = move(m_x[i],  st, 639, m_wrap[i]);
      if (u || d || l || r) m_h[i] = (m_h[i] >= 8) ? 8 : m_h[i] + 1;
      else                  m_h[i] = 0;
      if (zi)      m_z[i] = (m_z[i] < 7) ? m_z[i] + 1 : 7;
      else if (zo) m_z[i] = (m_z[i] > 0) ? m_z[i] - 1 : 0;
    end
    m_ticks++;
  endtask

  task automatic check_state();
    chk("clamp_x", nav0.origin_x, m_x[0]);
    chk("clamp_y", nav0.origin_y, m_y[0]);
    chk("clamp_zoom", nav0.zoom, m_z[0]);
    chk("wrap_x", nav1.origin_x, m_x[1]);
    chk("wrap_y", nav1.origin_y, m_y[1]);
    chk("wrap_zoom", nav1.zoom, m_z[1]);
    chk("disp_enable", nav0.disp_enable, (m_ticks >= 6) ? 1 : 0);
    chk("calc_enable", nav0.calc_enable, (m_ticks >= 15) ? 1 : 0);
    chk("frame_ticks", tick_seen - tick_base, m_ticks);
    chk("rgb", int'({nav0.red, nav0.green, nav0.blue}), m_rgb);
  endtask

  task automatic release_keys();
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1; zoom_in = 1'b1; zoom_out = 1'b1;
  endtask

  // Arguments are "pressed" flags; the pins themselves are active-low.
  task automatic do_blank(input bit u, input bit d, input bit l, input bit r,
                          input bit zi, input bit zo, input int hi_len);
    @(negedge clk);
    up = ~u; down = ~d; left = ~l; right = ~r; zoom_in = ~zi; zoom_out = ~zo;
    vnotactive = 1'b1;
    repeat (hi_len) @(negedge clk);
    vnotactive = 1'b0;
    model_frame(u, d, l, r, zi, zo);
    for (int k = 0; k < 4; k++) begin
      {pix_r, pix_g, pix_b} = 3'($urandom);
      @(posedge clk);
      #1;
      if (m_ticks >= 6) m_rgb = int'({pix_r, pix_g, pix_b});
      chk("rgb_follow", int'({nav0.red, nav0.green, nav0.blue}), m_rgb);
      @(negedge clk);
    end
    release_keys();
    check_state();
  endtask

  task automatic random_blanks(input int n);
    for (int i = 0; i < n; i++) begin
      do_blank($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               int'($urandom_range(2, 10)));
    end
  endtask

  initial begin
    release_keys();
    vnotactive = 1'b0;
    {pix_r, pix_g, pix_b} = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    tick_base = tick_seen;
    check_state();
    chk("reset_tick", nav0.frame_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_blank(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i == 0) ? 50 : 3);
      if (i == 0) chk("wrap_up_first", nav1.origin_y, 1022);
      if (i == 7) chk("up8_y", nav0.origin_y, 184);
    end
    chk("up10_y", nav0.origin_y, 168);

    do_blank(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    do_blank(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    chk("updown_y", nav0.origin_y, 166);
    chk("inout_zoom", nav0.zoom, 1);
    for (int i = 0; i < 9; i++) do_blank(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    chk("zoom_sat", nav0.zoom, 7);

    for (int i = 0; i < 45; i++) do_blank(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    chk("clamp_x_low", nav0.origin_x, 0);
    chk("clamp_y_low", nav0.origin_y, 0);
    for (int i = 0; i < 90; i++) do_blank(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    chk("clamp_x_high", nav0.origin_x, 639);
    chk("clamp_y_high", nav0.origin_y, 479);

    random_blanks(60);

    @(negedge clk);
    left = 1'b0;
    vnotactive = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    tick_base = tick_seen;
    check_state();
    chk("midapply_tick", nav0.frame_tick, 0);
    @(negedge clk);
    vnotactive = 1'b0;
    release_keys();
    @(negedge clk);
    rst_n = 1'b1;
    random_blanks(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/viewport_nav.md
VIEWPORT_NAV -- requirements
Module: viewport_nav

Interface
REQ-001 SHALL have parameters (name, default, meaning): COORD_W, 10, origin coordinate width; X_INIT, 300, reset origin X; Y_INIT, 200, reset origin Y; X_MAX, 639, X clamp limit; Y_MAX, 479, Y clamp limit; STEP, 2, base pan step; ACCEL_FRAMES, 8, held blanks before fast step; FAST_MUL, 4, fast-step multiplier; WRAP, 0, 1=modulo wrap, 0=clamp; ZOOM_MAX, 7, highest zoom level; DISP_DELAY, 6, blanks before display enable; CALC_DELAY, 15, blanks before calc enable.
REQ-002 SHALL have ports (name, direction, width, meaning): CLK in 1 system clock; RST in 1 asynchronous active-low reset; up/down/left/right in 1 each, active-low pan keys; zoom_in/zoom_out in 1 each, active-low zoom keys; vnotactive in 1, high during vertical blank; pix_r/pix_g/pix_b in 1 each, pixel colour from calc engine; origin_x out COORD_W; origin_y out COORD_W; zoom out 3; disp_enable out 1; calc_enable out 1; red/green/blue out 1 each, registered display colour; frame_tick out 1, one-cycle pulse at blank start.

Function
REQ-003 SHALL detect blank start as vnotactive 0->1 between consecutive CLK edges (registered previous value) and pulse frame_tick for exactly one cycle.
REQ-004 SHALL run a 3-state navigator FSM: WAIT_BLANK -> (vnotactive=1) APPLY -> DONE -> (vnotactive=0) WAIT_BLANK; APPLY lasts exactly one cycle; state encoding 2'b11 SHALL return to WAIT_BLANK.
REQ-005 SHALL update origin/zoom only in APPLY, hence at most once per blank interval regardless of blank length.
REQ-006 In APPLY: up (0) decrements origin_y, else down (0) increments; left decrements origin_x, else right increments; up beats down, left beats right when both pressed.
REQ-007 SHALL use step STEP while hold_cnt < ACCEL_FRAMES, else STEP*FAST_MUL; hold_cnt increments (saturating at ACCEL_FRAMES) in each APPLY with any pan key pressed and clears in an APPLY with none pressed.
REQ-008 With WRAP=0: decrement below 0 SHALL give 0; increment above X_MAX/Y_MAX SHALL give the limit; arithmetic done at COORD_W+1 bits.
REQ-009 With WRAP=1: results SHALL be modulo 2^COORD_W, no clamping.
REQ-010 In APPLY: zoom_in (0) increments zoom saturating at ZOOM_MAX, else zoom_out (0) decrements saturating at 0; zoom_in wins if both.
REQ-011 SHALL count frame_ticks in a saturating 5-bit startup counter; disp_enable set when count reaches DISP_DELAY, calc_enable set when it reaches CALC_DELAY; both sticky until reset.
REQ-012 While disp_enable=1, red/green/blue SHALL register pix_r/g/b each cycle (latency 1); while 0, hold value.
REQ-013 Pan and zoom SHALL operate independent of disp_enable/calc_enable.

Reset
REQ-014 On RST=0 (asynchronous, any cycle, including mid-APPLY): origin_x=X_INIT, origin_y=Y_INIT, zoom=0, hold_cnt=0, state WAIT_BLANK, startup count 0, disp_enable=0, calc_enable=0, red=green=blue=1, frame_tick=0, vnotactive history=0.
REQ-015 Release SHALL be synchronous to CLK; first blank after release is counted only on a fresh 0->1 edge.

Structure
REQ-016 FSM state encodings and default parameter constants SHALL live in shared package chaos_pkg.
REQ-017 Pan axis arithmetic (step, direction, clamp/wrap) SHALL be one sub-module axis_step instantiated twice (X, Y).

Verification
REQ-018 Reset, hold all keys 1 -> origin 300/200, zoom 0, RGB=111, enables 0.
REQ-019 Hold up=0 for 10 blanks (defaults) -> origin_y: 8 blanks at step 2 to 184, then two at step 8 to 168; one change per blank even with 50-cycle blank.
REQ-020 WRAP=0, origin_x driven to 1, left=0 one blank -> origin_x=0; right held at 638 -> 639 then stays 639. WRAP=1, origin_x=0, left -> 1022.
REQ-021 up=down=0 and zoom_in=zoom_out=0 at one blank -> origin_y-2, zoom+1; zoom_in for 9 blanks -> zoom=7.
REQ-022 Count blanks -> disp_enable after 6th tick, calc_enable after 15th; pix change then visible on red/green/blue next cycle, not before 6th tick.
REQ-023 Assert RST=0 during APPLY -> all outputs at reset values immediately, no partial origin update.
